// File: rtl/dm_be.sv
// Byte-addressable data memory for the MEM stage: sb/sh/sw with lane merge, lb/lbu/lh/lhu/lw with
// extension, address-error flags, and a post-reset sweep that zeroes one word per cycle.
module dm_be #(
    parameter int unsigned DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          LOG_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  st_type,
    input  logic [2:0]  ld_type,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [31:0] PC,
    output logic [31:0] data_out,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        busy
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {StClear, StRun} state_t;

    state_t        r_state, w_state_d;
    logic [AW-1:0] r_ptr, w_ptr_d;
    logic          r_busy, w_busy_d;
    logic [31:0]   r_mem [DEPTH];

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_oor;
    logic          w_st_mis;
    logic          w_ld_mis;
    logic          w_commit;
    logic [31:0]   w_word;
    logic [31:0]   w_merged;
    logic [31:0]   w_load;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign w_off  = Addr - BASE_ADDR;
    assign w_idx  = w_off[AW+1:2];
    assign w_lane = w_off[1:0];
    assign w_oor  = (Addr < BASE_ADDR) | ({1'b0, w_off} >= LIMIT);

    always_comb begin
        w_st_mis = 1'b0;
        case (st_type)
            2'b10:   w_st_mis = w_lane[0];
            2'b11:   w_st_mis = (w_lane != 2'b00);
            default: w_st_mis = 1'b0;
        endcase
    end

    always_comb begin
        w_ld_mis = 1'b0;
        case (ld_type)
            3'b001, 3'b010: w_ld_mis = w_lane[0];
            3'b011, 3'b100: w_ld_mis = 1'b0;
            default:        w_ld_mis = (w_lane != 2'b00);
        endcase
    end

    assign exc_ades = (st_type != 2'b00) & (w_oor | w_st_mis);
    assign exc_adel = (st_type == 2'b00) & (w_oor | w_ld_mis);
    assign w_commit = (r_state == StRun) & (st_type != 2'b00) & ~exc_ades;

    // Guarded read: for non-power-of-two depths the index can exceed the array.
    assign w_word = w_oor ? 32'h0 : r_mem[w_idx];

    always_comb begin
        w_merged = w_word;
        case (st_type)
            2'b01:   w_merged[{w_lane, 3'b000} +: 8]     = WD[7:0];
            2'b10:   w_merged[{w_lane[1], 4'b0000} +: 16] = WD[15:0];
            2'b11:   w_merged = WD;
            default: w_merged = w_word;
        endcase
    end

    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load = w_word;
        case (ld_type)
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = {16'h0000, w_half};
            3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h000000, w_byte};
            default: w_load = w_word;
        endcase
    end

    assign data_out = (r_busy | exc_adel | w_oor) ? 32'h0 : w_load;
    assign busy     = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StClear;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_busy  <= w_busy_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_busy_d  = r_busy;
        case (r_state)
            StClear: begin
                w_ptr_d = r_ptr + 1'b1;
                if (r_ptr == LAST) begin
                    w_state_d = StRun;
                    w_busy_d  = 1'b0;
                    w_ptr_d   = '0;
                end
            end
            StRun:   w_state_d = StRun;
            default: w_state_d = StClear;
        endcase
    end

    // Array has no reset; the sweep is the only clearing mechanism.
    always_ff @(posedge clk) begin
        if (r_state == StClear) begin
            r_mem[r_ptr] <= 32'h0;
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    if (LOG_EN) begin : g_log
        always_ff @(posedge clk) begin
            if (w_commit) begin
                $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00}, w_merged);
            end
        end
    end

endmodule

// File: tb/tb_dm_be.sv
// Randomized bench for dm_be: a lane-arithmetic memory model checked every cycle, plus literal
// expectations for the documented load/store/exception cases and sweep timing.
module tb_dm_be;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  st_type;
    logic [2:0]  ld_type;
    logic [31:0] Addr, WD, PC;
    logic [31:0] data_out;
    logic        exc_adel, exc_ades, busy;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    logic [31:0] mem_m [DEPTH];
    int          busy_cnt = 0;

    dm_be #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LOG_EN    (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .st_type  (st_type),
        .ld_type  (ld_type),
        .Addr     (Addr),
        .WD       (WD),
        .PC       (PC),
        .data_out (data_out),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_oor();
        longint a = longint'(Addr);
        longint b = longint'(BASE);
        return (a < b) || ((a - b) >= longint'(DEPTH) * 4);
    endfunction

    function automatic int model_lane();
        return int'((Addr - BASE) % 4);
    endfunction

    function automatic void model_out(output logic [31:0] d, output logic adel, output logic ades);
        int lane = model_lane();
        bit oor = model_oor();
        bit mis_s, mis_l;
        logic [31:0] w, b, h;
        mis_s = (st_type == 2 && (lane % 2) != 0) || (st_type == 3 && lane != 0);
        if (ld_type == 1 || ld_type == 2)      mis_l = (lane % 2) != 0;
        else if (ld_type == 3 || ld_type == 4) mis_l = 0;
        else                                   mis_l = lane != 0;
        ades = (st_type != 0) && (oor || mis_s);
        adel = (st_type == 0) && (oor || mis_l);
        d = 0;
        if (busy_cnt == 0 && !adel && !oor) begin
            w = mem_m[(Addr - BASE) / 4];
            b = (w >> (8 * lane)) & 32'hFF;
            h = (w >> (16 * (lane / 2))) & 32'hFFFF;
            case (ld_type)
                1:       d = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
                2:       d = h;
                3:       d = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
                4:       d = b;
                default: d = w;
            endcase
        end
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input int lane);
        case (st_type)
            1:       return (w & ~(32'hFF << (8 * lane))) | ((WD & 32'hFF) << (8 * lane));
            2:       return (w & ~(32'hFFFF << (16 * (lane / 2)))) |
                            ((WD & 32'hFFFF) << (16 * (lane / 2)));
            default: return WD;
        endcase
    endfunction

    // Model: reset wipes everything; DEPTH edges of busy; afterwards legal stores merge.
    always @(posedge clk or posedge reset) begin
        logic [31:0] d;
        logic adel, ades;
        if (reset) begin
            busy_cnt <= DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] <= 32'h0;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (st_type != 0) begin
            model_out(d, adel, ades);
            if (!ades) mem_m[(Addr - BASE) / 4] <= model_merge(mem_m[(Addr - BASE) / 4],
                                                                model_lane());
        end
    end

    always @(negedge clk) begin
        logic [31:0] d;
        logic adel, ades;
        if (run_chk) begin
            model_out(d, adel, ades);
            chk("cyc_busy", {31'b0, busy}, {31'b0, busy_cnt > 0});
            chk("cyc_data", data_out, d);
            chk("cyc_adel", {31'b0, exc_adel}, {31'b0, adel});
            chk("cyc_ades", {31'b0, exc_ades}, {31'b0, ades});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [1:0] st, input logic [2:0] ld, input logic [31:0] a,
                       input logic [31:0] d);
        st_type = st;
        ld_type = ld;
        Addr    = a;
        WD      = d;
        PC      = $urandom;
    endtask

    task automatic op(input logic [1:0] st, input logic [2:0] ld, input logic [31:0] a,
                      input logic [31:0] d);
        set(st, ld, a, d);
        tick();
    endtask

    task automatic peek(input logic [2:0] ld, input logic [31:0] a);
        set(2'b00, ld, a, 32'h0);
        #2;
    endtask

    task automatic sweep_check(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            chk(name, {31'b0, busy}, 32'd1);
            tick();
        end
        chk({name, "_end"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        set(2'b00, 3'b000, 32'h0, 32'h0);
        #1 reset = 1'b1;
        run_chk = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        // Word store held through the whole sweep must be dropped.
        set(2'b11, 3'b000, 32'h0, 32'hDEAD_BEEF);
        sweep_check("sweep_busy");
        peek(3'b000, 32'h0);
        chk("busy_store_dropped", data_out, 32'h0);
        tick();
        for (int a = 0; a < DEPTH * 4; a += 4) begin
            peek(3'b000, a);
            chk("cleared_word", data_out, 32'h0);
            tick();
        end

        op(2'b11, 3'b000, 32'h0, 32'h8000_00F1);
        peek(3'b011, 32'h0);  chk("lb_0", data_out, 32'hFFFF_FFF1);  tick();
        peek(3'b100, 32'h0);  chk("lbu_0", data_out, 32'h0000_00F1); tick();
        peek(3'b001, 32'h2);  chk("lh_2", data_out, 32'hFFFF_8000);  tick();
        peek(3'b010, 32'h2);  chk("lhu_2", data_out, 32'h0000_8000); tick();

        op(2'b11, 3'b000, 32'h4, 32'h1122_3344);
        op(2'b01, 3'b000, 32'h6, 32'h0000_00AB);
        peek(3'b000, 32'h4);  chk("sb_merge", data_out, 32'h11AB_3344); tick();
        op(2'b10, 3'b000, 32'h4, 32'h0000_BEEF);
        peek(3'b000, 32'h4);  chk("sh_merge", data_out, 32'h11AB_BEEF); tick();

        set(2'b11, 3'b000, 32'h2, 32'hFFFF_FFFF);
        #2 chk("sw_mis_ades", {31'b0, exc_ades}, 32'd1);
        tick();
        peek(3'b000, 32'h0);  chk("sw_mis_nowrite", data_out, 32'h8000_00F1); tick();
        peek(3'b001, 32'h3);
        chk("lh_mis_adel", {31'b0, exc_adel}, 32'd1);
        chk("lh_mis_data", data_out, 32'h0);
        tick();
        peek(3'b000, DEPTH * 4);
        chk("lw_oor_adel", {31'b0, exc_adel}, 32'd1);
        tick();

        set(2'b11, 3'b000, 32'h8, 32'h0000_0055);
        #2 chk("rdw_old", data_out, 32'h0);
        tick();
        peek(3'b000, 32'h8);  chk("rdw_new", data_out, 32'h0000_0055); tick();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, DEPTH * 4 + 7);
            op(($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), a, $urandom);
        end

        set(2'b00, 3'b000, 32'h4, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        #1 chk("midsweep_reset_busy", {31'b0, busy}, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        set(2'b11, 3'b000, 32'h4, 32'h1234_5678);
        sweep_check("resweep_busy");
        peek(3'b000, 32'h4);  chk("resweep_cleared", data_out, 32'h0); tick();

        for (int i = 0; i < 100; i++) begin
            op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)),
               $urandom_range(0, DEPTH * 4 - 1), $urandom);
        end

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
